// File: rtl/ahb_apb_bridge_gen2.sv
// ahb_apb_bridge_gen2: AHB-lite to multi-slave APB bridge with decode-error and timeout responses
module ahb_apb_bridge_gen2 #(
  parameter int DATA_W = 32,
  parameter int PADDR_W = 5,
  parameter int NSLV = 4,
  parameter int TIMEOUT = 16,
  localparam int SEL_W = (NSLV > 2) ? $clog2(NSLV) : 1
) (
  input  logic                     hclk_i,
  input  logic                     reset_n_i,
  input  logic                     hsel_i,
  input  logic [SEL_W+PADDR_W-1:0] haddr_i,
  input  logic                     hwrite_i,
  input  logic [1:0]               htrans_i,
  input  logic                     hready_i,
  input  logic [DATA_W-1:0]        hwdata_i,
  output logic                     hreadyout_o,
  output logic                     hresp_o,
  output logic [DATA_W-1:0]        hrdata_o,
  output logic [NSLV-1:0]          psel_o,
  output logic [PADDR_W-1:0]       paddr_o,
  output logic                     pwrite_o,
  output logic                     penable_o,
  output logic [DATA_W-1:0]        pwdata_o,
  input  logic [NSLV*DATA_W-1:0]   prdata_i,
  input  logic [NSLV-1:0]          pready_i,
  input  logic [NSLV-1:0]          pslverr_i
);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  localparam logic [SEL_W:0] NSLV_L = (SEL_W+1)'(NSLV);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d, hidx;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, hrdata_q, hrdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic pwrite_q, pwrite_d, penable_q, penable_d, hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic acc, idx_ok, rdy, err;
  assign hidx = haddr_i[SEL_W+PADDR_W-1 -: SEL_W];
  assign idx_ok = {1'b0, hidx} < NSLV_L;
  assign acc = hsel_i & hready_i & htrans_i[1] & (state_q == IDLE || state_q == ERR2);
  assign rdy = pready_i[idx_q];
  assign err = pslverr_i[idx_q];
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    paddr_d = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE, ERR2: begin
        state_d = !acc ? IDLE : !idx_ok ? ERR1 : hwrite_i ? WDATA : SETUP;
        if (acc && idx_ok) begin
          idx_d = hidx;
          paddr_d = haddr_i[PADDR_W-1:0];
          pwrite_d = hwrite_i;
        end
      end
      WDATA: begin
        state_d = SETUP;
        pwdata_d = hwdata_i;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d = '0;
      end
      ACCESS: begin
        // read data is captured even when the slave flags an error
        if (rdy) begin
          state_d = err ? ERR1 : IDLE;
          if (!pwrite_q) hrdata_d = prdata_i[32'(idx_q) * DATA_W +: DATA_W];
        end else if (cnt_q == TO_LAST) state_d = ERR1;
        else cnt_d = cnt_q + 8'd1;
      end
      ERR1: state_d = ERR2;
      default: state_d = IDLE;
    endcase
    psel_d = (state_d == SETUP || state_d == ACCESS) ? NSLV'(1) << idx_d : '0;
    penable_d = state_d == ACCESS;
    hreadyout_d = state_d == IDLE || state_d == ERR2;
    hresp_d = state_d == ERR1 || state_d == ERR2;
  end
  always_ff @(posedge hclk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q <= '0;
      psel_q <= '0;
      penable_q <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      cnt_q <= cnt_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q <= hresp_d;
    end
  end
  assign hreadyout_o = hreadyout_q;
  assign hresp_o = hresp_q;
  assign hrdata_o = hrdata_q;
  assign psel_o = psel_q;
  assign paddr_o = paddr_q;
  assign pwrite_o = pwrite_q;
  assign penable_o = penable_q;
  assign pwdata_o = pwdata_q;
endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// tb_ahb_apb_bridge_gen2: directed and random transfers checked against a timeline model and slave memory
module tb_ahb_apb_bridge_gen2;
  localparam int NS = 3;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n, hsel, hwrite, hready, hreadyout, hresp, pwrite, penable;
  logic [6:0] haddr;
  logic [1:0] htrans;
  logic [31:0] hwdata, hrdata, pwdata, exp_hrd;
  logic [2:0] psel, pready, pslverr;
  logic [4:0] paddr;
  logic [95:0] prdata;
  logic [31:0] slv [4][32];
  logic [31:0] ref_m [4][32];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ahb_apb_bridge_gen2 #(.DATA_W(32), .PADDR_W(5), .NSLV(NS), .TIMEOUT(TO)) dut (
    .hclk_i(clk), .reset_n_i(rst_n), .hsel_i(hsel), .haddr_i(haddr), .hwrite_i(hwrite),
    .htrans_i(htrans), .hready_i(hready), .hwdata_i(hwdata), .hreadyout_o(hreadyout),
    .hresp_o(hresp), .hrdata_o(hrdata), .psel_o(psel), .paddr_o(paddr), .pwrite_o(pwrite),
    .penable_o(penable), .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle();
    chk("idle_hreadyout", 32'(hreadyout), 32'd1);
    chk("idle_hresp", 32'(hresp), 32'd0);
    chk("idle_psel", 32'(psel), 32'd0);
    chk("idle_penable", 32'(penable), 32'd0);
    chk("idle_hrdata", hrdata, exp_hrd);
  endtask
  // One transfer: model predicts every cycle from accept until HREADYOUT returns high
  task automatic xfer(input int idx, input logic [4:0] pa, input logic w, input logic [31:0] wd,
                      input int waits, input logic err);
    bit ok, tmo, bad, in_s, in_a;
    int s, e, last;
    ok = idx < NS;
    tmo = ok && waits >= TO;
    bad = !ok || tmo || err;
    s = !ok ? 0 : w ? 2 : 1;
    e = !ok ? 0 : s + (tmo ? TO : waits + 1);
    last = e + (bad ? 2 : 1);
    hsel = 1'b1;
    hready = 1'b1;
    htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    haddr = {2'(idx), pa};
    hwrite = w;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      in_s = ok && k == s;
      in_a = ok && k > s && k <= e;
      if (k == e + 1 && ok && !tmo && !w) exp_hrd = ref_m[idx][pa];
      chk("psel", 32'(psel), (in_s || in_a) ? (32'd1 << idx) : 32'd0);
      chk("penable", 32'(penable), 32'(in_a));
      chk("hreadyout", 32'(hreadyout), 32'(k > e && (!bad || k == e + 2)));
      chk("hresp", 32'(hresp), 32'(k > e && bad));
      chk("hrdata", hrdata, exp_hrd);
      if (in_s || in_a) begin
        chk("paddr", 32'(paddr), 32'(pa));
        chk("pwrite", 32'(pwrite), 32'(w));
      end
      if (in_a && w) chk("pwdata", pwdata, wd);
      pready = 3'($urandom);
      pslverr = 3'($urandom);
      prdata = {$urandom, $urandom, $urandom};
      if (in_a) begin
        pready[idx] = (k - s) > waits;
        pslverr[idx] = err;
        prdata[idx*32 +: 32] = slv[idx][paddr];
        if (pready[idx] && w && !err) slv[idx][paddr] = pwdata;
      end
      hwdata = (k == 1) ? wd : $urandom;
      if (k < last) begin
        hsel = 1'($urandom);
        htrans = 2'($urandom);
        hready = 1'($urandom);
        haddr = 7'($urandom);
        hwrite = 1'($urandom);
      end else begin
        hsel = 1'b0;
        htrans = 2'b00;
        hready = 1'b1;
      end
    end
    if (ok && !tmo && !err && w) ref_m[idx][pa] = wd;
  endtask
  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 32; j++) begin
        slv[i][j] = $urandom;
        ref_m[i][j] = slv[i][j];
      end
    slv[1][3] = 32'h12345678;
    ref_m[1][3] = 32'h12345678;
    rst_n = 1'b0;
    hsel = 1'b0;
    hwrite = 1'b0;
    htrans = 2'b00;
    hready = 1'b1;
    haddr = '0;
    hwdata = '0;
    pready = '0;
    pslverr = '0;
    prdata = '0;
    exp_hrd = '0;
    repeat (2) @(negedge clk);
    chk_idle();
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hsel = i != 1;
      hready = i != 2;
      htrans = (i == 0) ? 2'b01 : (i == 3) ? 2'b00 : 2'b10;
      haddr = 7'($urandom);
      hwrite = 1'($urandom);
      @(negedge clk);
      chk_idle();
    end
    hsel = 1'b0;
    htrans = 2'b00;
    hready = 1'b1;
    xfer(2, 5'd5, 1'b1, 32'hDEADBEEF, 0, 1'b0);
    xfer(1, 5'd3, 1'b0, 32'h0, 3, 1'b0);
    chk("read_12345678", hrdata, 32'h12345678);
    xfer(0, 5'd7, 1'b1, 32'hA5A5_0F0F, 0, 1'b0);
    xfer(0, 5'd7, 1'b0, 32'h0, 1, 1'b0);
    xfer(2, 5'd9, 1'b1, 32'h0BAD_CAFE, 2, 1'b0);
    xfer(2, 5'd9, 1'b0, 32'h0, 0, 1'b0);
    xfer(2, 5'd5, 1'b0, 32'h0, 0, 1'b0);
    chk("readback_deadbeef", hrdata, 32'hDEADBEEF);
    xfer(0, 5'd1, 1'b0, 32'h0, 0, 1'b1);
    xfer(0, 5'd2, 1'b1, 32'h1111_2222, 1, 1'b1);
    xfer(0, 5'd2, 1'b0, 32'h0, 0, 1'b0);
    xfer(1, 5'd4, 1'b0, 32'h0, TO, 1'b0);
    xfer(2, 5'd6, 1'b1, 32'h3333_4444, TO + 3, 1'b0);
    xfer(3, 5'd5, 1'b1, 32'h5555_6666, 0, 1'b0);
    xfer(3, 5'd0, 1'b0, 32'h0, 0, 1'b0);
    xfer(1, 5'd3, 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    chk_idle();
    hsel = 1'b1;
    htrans = 2'b10;
    haddr = {2'd1, 5'd2};
    hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0;
    htrans = 2'b00;
    pready = '0;
    @(negedge clk);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    rst_n = 1'b0;
    hsel = 1'b1;
    htrans = 2'b10;
    haddr = {2'd0, 5'd1};
    @(negedge clk);
    rst_n = 1'b1;
    hsel = 1'b0;
    htrans = 2'b00;
    exp_hrd = '0;
    chk_idle();
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr2", 32'(paddr), 32'd0);
    chk("rst_pwdata2", pwdata, 32'd0);
    @(negedge clk);
    chk_idle();
    xfer(1, 5'd2, 1'b0, 32'h0, 1, 1'b0);
    repeat (80) begin
      int idx, waits;
      logic [4:0] pa;
      logic w, er;
      idx = $urandom_range(0, 3);
      waits = $urandom_range(0, 5);
      pa = 5'($urandom);
      w = 1'($urandom);
      er = $urandom_range(0, 3) == 0;
      xfer(idx, pa, w, $urandom, waits, er);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk_idle();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
